octal_scan_ctrl: RTL and testbench

OCTAL_SCAN_CTRL -- requirements
Module: octal_scan_ctrl

---
 rtl/octal_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_octal_scan_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/octal_scan_ctrl.sv
// Four-digit octal display scanner with anti-ghost blanking and frame-aligned word commit.
// Optional macro LEADING_ZERO_BLANK_EN keeps digits above the most-significant nonzero digit dark.
module octal_scan_ctrl #(
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [11:0] data_in,
  output logic        load_ack,
  output logic [2:0]  digit_val,
  output logic [3:0]  an_n,
  output logic [1:0]  digit_idx
);

  localparam int MAXC = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  logic [1:0]    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    r_idx, w_idx_nxt;
  logic [11:0]   r_disp, w_disp_nxt;
  logic [11:0]   r_pword;
  logic          r_pend;
  logic          r_ack;
  logic [2:0]    r_val, w_val_nxt;
  logic [3:0]    r_an_n, w_an_nxt;
  logic          w_commit;
  logic          w_lit;
  logic [2:0]    w_digit;

  // Commits land only while dark or at the frame boundary, so a frame never mixes two words.
  always_comb begin
    w_commit   = ((r_state == S_OFF) ||
                  (r_state == S_SHOW && r_idx == 2'd3 && r_cnt == TICK_LAST)) &&
                 (load || r_pend);
    w_disp_nxt = w_commit ? (load ? data_in : r_pword) : r_disp;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    if (!en) begin
      w_state_nxt = S_OFF;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state_nxt = S_BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
        S_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_nxt = S_SHOW;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (r_cnt == TICK_LAST) begin
            w_state_nxt = S_BLANK;
            w_cnt_nxt   = '0;
            w_idx_nxt   = r_idx + 2'd1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_OFF;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are computed from next-state values so they change on the same edge as the state.
  always_comb begin
    case (w_idx_nxt)
      2'd0:    w_digit = w_disp_nxt[2:0];
      2'd1:    w_digit = w_disp_nxt[5:3];
      2'd2:    w_digit = w_disp_nxt[8:6];
      default: w_digit = w_disp_nxt[11:9];
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    case (w_idx_nxt)
      2'd0:    w_lit = 1'b1;
      2'd1:    w_lit = |w_disp_nxt[11:3];
      2'd2:    w_lit = |w_disp_nxt[11:6];
      default: w_lit = |w_disp_nxt[11:9];
    endcase
`else
    w_lit = 1'b1;
`endif
    w_val_nxt = (w_state_nxt == S_OFF) ? 3'd0 : w_digit;
    w_an_nxt  = (w_state_nxt == S_SHOW && w_lit) ? ~(4'b0001 << w_idx_nxt) : 4'b1111;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_OFF;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_disp  <= '0;
      r_pword <= '0;
      r_pend  <= 1'b0;
      r_ack   <= 1'b0;
      r_val   <= '0;
      r_an_n  <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_disp  <= w_disp_nxt;
      r_ack   <= w_commit;
      r_val   <= w_val_nxt;
      r_an_n  <= w_an_nxt;
      if (w_commit) begin
        r_pend <= 1'b0;
      end else if (load) begin
        r_pend  <= 1'b1;
        r_pword <= data_in;
      end
    end
  end

  assign load_ack  = r_ack;
  assign digit_val = r_val;
  assign an_n      = r_an_n;
  assign digit_idx = r_idx;

endmodule

// File: tb/tb_octal_scan_ctrl.sv
// Bench for octal_scan_ctrl: directed vector table, corner sequences and random traffic vs a frame-position model.
module tb_octal_scan_ctrl;

  localparam int TICK  = 4;
  localparam int BLANK = 2;
  localparam int SLOT  = TICK + BLANK;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        load;
  logic [11:0] data_in;
  logic        load_ack;
  logic [2:0]  digit_val;
  logic [3:0]  an_n;
  logic [1:0]  digit_idx;

  int checks = 0;
  int errors = 0;
  int acks;

  octal_scan_ctrl #(.TICK_DIV(TICK), .BLANK_CYC(BLANK)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .data_in(data_in),
    .load_ack(load_ack), .digit_val(digit_val), .an_n(an_n), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  // Model: scanning flag plus cycles since scan start; everything else follows from frame position.
  bit          m_on;
  int          m_t;
  logic [11:0] m_disp;
  logic [11:0] m_pw;
  bit          m_pend;
  bit          m_ack;

  task automatic mdl_reset();
    m_on = 0; m_t = 0; m_disp = '0; m_pw = '0; m_pend = 0; m_ack = 0;
  endtask

  task automatic mdl_edge(input logic e, input logic l, input logic [11:0] d);
    bit slot_ok;
    slot_ok = !m_on || ((m_t % FRAME) == FRAME - 1);
    if (slot_ok && (l || m_pend)) begin
      m_disp = l ? d : m_pw;
      m_pend = 0;
      m_ack  = 1;
    end else begin
      m_ack = 0;
      if (l) begin m_pend = 1; m_pw = d; end
    end
    if (!e) m_on = 0;
    else if (!m_on) begin m_on = 1; m_t = 0; end
    else m_t++;
  endtask

  function automatic int exp_idx();
    return m_on ? (m_t % FRAME) / SLOT : 0;
  endfunction

  function automatic int exp_val();
    logic [11:0] sh;
    if (!m_on) return 0;
    sh = m_disp >> (3 * exp_idx());
    return int'(sh[2:0]);
  endfunction

  function automatic int exp_an();
    bit lit;
    if (!m_on || ((m_t % FRAME) % SLOT) < BLANK) return 15;
`ifdef LEADING_ZERO_BLANK_EN
    lit = (exp_idx() == 0) || ((m_disp >> (3 * exp_idx())) != 0);
`else
    lit = 1;
`endif
    return lit ? (15 & ~(1 << exp_idx())) : 15;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic e, input logic l, input logic [11:0] d);
    en = e; load = l; data_in = d;
    @(posedge clk);
    mdl_edge(e, l, d);
    #1;
    chk("an_n", int'(an_n), exp_an());
    chk("digit_idx", int'(digit_idx), exp_idx());
    chk("digit_val", int'(digit_val), exp_val());
    chk("load_ack", int'(load_ack), int'(m_ack));
    if (load_ack) acks++;
  endtask

  typedef struct {
    logic        en;
    logic        ld;
    logic [11:0] d;
    logic [3:0]  an;
    logic [1:0]  idx;
    logic [2:0]  val;
    logic        ack;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Start-up frame for 12'o7531, then en drop mid digit-2 show and re-enable.
    tbl.push_back('{1'b1, 1'b1, 12'o7531, 4'hF, 2'd0, 3'd1, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 12'o0000, 4'hF, 2'd0, 3'd1, 1'b0});
    for (int i = 0; i < 4; i++) tbl.push_back('{1'b1, 1'b0, 12'o0, 4'hE, 2'd0, 3'd1, 1'b0});
    for (int i = 0; i < 2; i++) tbl.push_back('{1'b1, 1'b0, 12'o0, 4'hF, 2'd1, 3'd3, 1'b0});
    for (int i = 0; i < 4; i++) tbl.push_back('{1'b1, 1'b0, 12'o0, 4'hD, 2'd1, 3'd3, 1'b0});
    for (int i = 0; i < 2; i++) tbl.push_back('{1'b1, 1'b0, 12'o0, 4'hF, 2'd2, 3'd5, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 12'o0000, 4'hB, 2'd2, 3'd5, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 12'o0000, 4'hF, 2'd0, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 12'o0000, 4'hF, 2'd0, 3'd1, 1'b0});

    reset = 1'b1; en = 1'b0; load = 1'b0; data_in = '0;
    mdl_reset();
    #2;
    chk("rst_an_n", int'(an_n), 15);
    chk("rst_idx", int'(digit_idx), 0);
    chk("rst_val", int'(digit_val), 0);
    chk("rst_ack", int'(load_ack), 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      en = tbl[i].en; load = tbl[i].ld; data_in = tbl[i].d;
      @(posedge clk);
      mdl_edge(tbl[i].en, tbl[i].ld, tbl[i].d);
      #1;
      chk("tbl_an_n", int'(an_n), int'(tbl[i].an));
      chk("tbl_idx", int'(digit_idx), int'(tbl[i].idx));
      chk("tbl_val", int'(digit_val), int'(tbl[i].val));
      chk("tbl_ack", int'(load_ack), int'(tbl[i].ack));
    end

    // Load during digit-1 slot is held until the frame boundary.
    repeat (7) step(1'b1, 1'b0, 12'o0);
    acks = 0;
    step(1'b1, 1'b1, 12'o1111);
    chk("no_tear_ack", int'(load_ack), 0);
    repeat (40) step(1'b1, 1'b0, 12'o0);
    chk("ack_count_boundary", acks, 1);
    chk("disp_after_1111", int'(digit_val), 1);

    // Two loads in one frame: newest wins, single ack.
    acks = 0;
    step(1'b1, 1'b1, 12'o2222);
    repeat (5) step(1'b1, 1'b0, 12'o0);
    step(1'b1, 1'b1, 12'o3333);
    repeat (40) step(1'b1, 1'b0, 12'o0);
    chk("ack_count_newest", acks, 1);
    chk("disp_after_3333", int'(digit_val), 3);

    // Back-to-back loads while dark: each commits immediately.
    step(1'b0, 1'b0, 12'o0);
    acks = 0;
    step(1'b0, 1'b1, 12'o0005);
    step(1'b0, 1'b1, 12'o0006);
    step(1'b0, 1'b0, 12'o0);
    chk("ack_count_off", acks, 2);
    step(1'b1, 1'b1, 12'o0005);
    repeat (FRAME + 3) step(1'b1, 1'b0, 12'o0);

    // Async reset mid-show with a pending word.
    while (((m_t % FRAME) % SLOT) < BLANK + 1) step(1'b1, 1'b0, 12'o0);
    step(1'b1, 1'b1, 12'o7777);
    #3;
    reset = 1'b1;
    #1;
    chk("async_an_n", int'(an_n), 15);
    chk("async_idx", int'(digit_idx), 0);
    chk("async_ack", int'(load_ack), 0);
    mdl_reset();
    @(negedge clk);
    reset = 1'b0;
    acks = 0;
    repeat (FRAME + 5) step(1'b1, 1'b0, 12'o0);
    chk("no_ack_after_reset", acks, 0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      step(logic'($urandom_range(0, 39) != 0), logic'($urandom_range(0, 7) == 0),
           12'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
